// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing a 4:1 mux path.
// Produces a registered one-hot grant, a registered mux select, and a bounded hold time.
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_0,
    input  logic req_1,
    input  logic req_2,
    input  logic req_3,
    output logic gnt_0,
    output logic gnt_1,
    output logic gnt_2,
    output logic gnt_3,
    output logic sel_0,
    output logic sel_1,
    output logic valid
);

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned CW = 8;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    req, others;
    logic [N-1:0]    gnt, gnt_nxt;
    logic [IW-1:0]   sel, sel_nxt;
    logic [IW-1:0]   last_idx, last_nxt;
    logic [CW-1:0]   hold_cnt, hold_nxt;
    logic            valid_nxt;
    logic [IW:0]     pick_any, pick_oth;
    logic            do_grant;
    logic [IW-1:0]   grant_idx;

    assign req                        = {req_3, req_2, req_1, req_0};
    assign {gnt_3, gnt_2, gnt_1, gnt_0} = gnt;
    assign {sel_1, sel_0}             = sel;

    // First requester after base in rotating order; MSB flags a hit.
    function automatic logic [IW:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] base);
        logic [IW:0]   pick;
        logic [IW-1:0] cand;
        pick = '0;
        for (int i = N; i >= 1; i--) begin
            cand = base + IW'(i);
            if (r[cand]) pick = {1'b1, cand};
        end
        return pick;
    endfunction

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        last_nxt  = last_idx;
        hold_nxt  = hold_cnt;
        valid_nxt = valid;
        do_grant  = 1'b0;
        grant_idx = '0;

        // In GRANT the holder is always last_idx, so masking it yields the competitors.
        others   = req & ~(N'(1) << last_idx);
        pick_any = rr_pick(req, last_idx);
        pick_oth = rr_pick(others, last_idx);

        case (state)
            IDLE: begin
                gnt_nxt   = '0;
                valid_nxt = 1'b0;
                if (pick_any[IW]) begin
                    do_grant  = 1'b1;
                    grant_idx = pick_any[IW-1:0];
                end
            end
            GRANT: begin
                if (!req[last_idx]) begin
                    if (pick_oth[IW]) begin
                        do_grant  = 1'b1;
                        grant_idx = pick_oth[IW-1:0];
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        valid_nxt = 1'b0;
                        hold_nxt  = '0;
                    end
                end else if (hold_cnt == CW'(MAX_HOLD - 1)) begin
                    if (pick_oth[IW]) begin
                        do_grant  = 1'b1;
                        grant_idx = pick_oth[IW-1:0];
                    end else begin
                        hold_nxt = '0;
                    end
                end else begin
                    hold_nxt = hold_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // gnt, sel and last_idx move together so sel never names a non-holder.
        if (do_grant) begin
            state_nxt = GRANT;
            gnt_nxt   = N'(1) << grant_idx;
            sel_nxt   = grant_idx;
            last_nxt  = grant_idx;
            hold_nxt  = '0;
            valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            last_idx <= IW'(3);
            hold_cnt <= '0;
            valid    <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            sel      <= sel_nxt;
            last_idx <= last_nxt;
            hold_cnt <= hold_nxt;
            valid    <= valid_nxt;
        end
    end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, legal range 2..255: the maximum number of consecutive cycles one grant lasts while another requester is waiting.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_0..req_3  input  1 each  request from requester n; held high for as long as the shared 4:1 mux path is needed.
REQ-005 gnt_0..gnt_3  output  1 each  registered grant, one-hot or all-zero.
REQ-006 sel_0, sel_1  output  1 each  registered select for the 4:1 mux; {sel_1,sel_0} is the binary index of the granted input (in_1 = sel_0 high, sel_1 low).
REQ-007 valid  output  1  high whenever any gnt_n is high.

Function
REQ-008 The block SHALL have two states: IDLE (no grant) and GRANT (exactly one gnt_n high).
REQ-009 The block SHALL keep a 2-bit last-granted index, last_idx. The search order for a new grant SHALL be last_idx+1, +2, +3, +4, mod 4 (round-robin).
REQ-010 IDLE, any req high: at the next edge, grant the first requester in the search order. Set gnt_n, sel to n, valid=1, last_idx=n, hold_cnt=0, and enter GRANT. Latency from req to gnt is 1 cycle.
REQ-011 IDLE, no req high: all gnt_n=0 and valid=0. sel_1/sel_0 SHALL hold their last value.
REQ-012 GRANT: hold_cnt (8 bits) SHALL increment by 1 each cycle while the granted req stays high.
REQ-013 Release: if the granted req is low at an edge, the grant SHALL end at that edge. If another req is high, the next requester in search order is granted at the same edge (no idle cycle). Otherwise the block enters IDLE.
REQ-014 Expiry: if the granted req is high, hold_cnt==MAX_HOLD-1, and at least one other req is high, the grant SHALL move at that edge to the next requester in search order. That requester is searched from the current index, excluding the current holder. A single grant therefore lasts at most MAX_HOLD cycles.
REQ-015 Expiry with no other req high: the current holder SHALL keep its grant and hold_cnt SHALL wrap to 0.
REQ-016 Handover (release or expiry): gnt, sel, and last_idx SHALL change at the same edge, so sel never names a requester other than the granted one while valid=1.
REQ-017 A req that goes high while another requester holds the grant SHALL NOT affect the grant until a release or expiry occurs.
REQ-018 A requester that drops req and reasserts it in the next cycle SHALL re-enter arbitration normally and receive no priority bonus.
REQ-019 Outputs SHALL be driven only from registers, with no combinational path from req to gnt or sel.

Reset
REQ-020 When rst_n=0, the block SHALL immediately, without waiting for clk, force: state=IDLE, gnt_0..gnt_3=0, valid=0, sel_1=0, sel_0=0, hold_cnt=0, last_idx=3 (so requester 0 has first priority).
REQ-021 Assertion of reset during GRANT SHALL abort the grant with no further handover.
REQ-022 After rst_n rises, the first arbitration SHALL occur at the first rising clk edge with any req high.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset with all req=1 -> gnt=0000, valid=0, sel=00 throughout reset; after release, gnt_0=1 and sel=00 at the first edge.
- Only req_2 raised at cycle 0 -> at edge 1: gnt_2=1, sel_1=1, sel_0=0, valid=1; req_2 dropped at cycle 5 -> edge 6: valid=0, sel stays 10.
- MAX_HOLD=4, all req held high -> grants run 0,1,2,3,0,… with exactly 4 cycles each and no cycle with valid=0.
- req_1 granted, req_3 pending, req_1 drops -> gnt_3=1 and sel=11 at the same edge gnt_1 falls; valid stays 1.
- MAX_HOLD=4, only req_0 high for 10 cycles -> gnt_0 continuous; hold_cnt follows 0,1,2,3,0,… with no handover.
- rst_n pulsed low mid-cycle during a grant to requester 2 -> gnt and valid go to 0 before the next clk edge; after release with req_2 and req_3 high, requester 2 is granted (last_idx=3).
